rule_trace_player: RTL
======================

# rule_trace_player

Synthesizable stimulus source that sits directly upstream of the generated protocol `system` model. It drives `io_en_a` (rule enable vector) and the system's `reset` from a loadable trace memory, one entry per clock. After the trace it can optionally continue with pseudo-random rule enables. This lets counterexample traces from the model checker be replayed on hardware or in emulation, and extended with random stress.

## Interface

Parameters:
- `EN_W`, default 7: width of the rule enable vector, equal to the `system` `io_en_a` width.
- `DEPTH`, default 16: number of trace entries (power of two).
- `AW`, default `$clog2(DEPTH)`: entry address width.
- `RAND_W`, default 16: width of the LFSR used in random mode.

Ports (name, direction, width, meaning):
- `clock`, in, 1: the single clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `wr_en`, in, 1: trace memory write strobe.
- `wr_addr`, in, AW: entry address.
- `wr_data`, in, EN_W+1: entry payload. Bit [EN_W] is the system reset bit; bits [EN_W-1:0] are the enables.
- `len`, in, AW+1: number of valid entries. Range 0..DEPTH; values above DEPTH clamp to DEPTH.
- `rand_cycles`, in, 16: number of random cycles to run after the trace. 0 means none.
- `seed`, in, RAND_W: LFSR seed. A value of 0 is replaced by 1.
- `start`, in, 1: pulse to begin playback.
- `abort`, in, 1: stop playback immediately.
- `busy`, out, 1: high in PLAY or RAND.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `cycle`, out, 32: count of entries emitted in the current run. Saturates.
- `io_en_a`, out, EN_W: registered enable vector to `system`.
- `sys_reset`, out, 1: registered reset to `system`.

## Operation

- States are IDLE, PLAY, RAND and FIN.
- **IDLE**
  - `io_en_a` is 0 and `sys_reset` is 1, so the system is held in reset.
  - `wr_en` writes `wr_data` into `mem[wr_addr]`.
  - `start` with `len` > 0: go to PLAY, entry pointer = 0, `cycle` = 0, latch `len` and `rand_cycles`.
  - `start` with `len` = 0 and `rand_cycles` > 0: go to RAND.
  - `start` with both 0: go to FIN.
- **PLAY**
  - Each cycle, register `mem[ptr]` onto {`sys_reset`, `io_en_a`}, increment `ptr` and `cycle`.
  - The cycle that emits entry `len`-1 moves to RAND if the latched `rand_cycles` > 0, otherwise to FIN.
  - `wr_en` is ignored while `busy`.
- **RAND**
  - Each cycle, `io_en_a` = LFSR[EN_W-1:0] and `sys_reset` = 0.
  - The LFSR advances every cycle; polynomial x^16+x^14+x^13+x^11+1 for RAND_W=16.
  - A down-counter loads the latched `rand_cycles` on entry. The last random cycle moves to FIN.
- **FIN**
  - Lasts one cycle: `done` = 1, `io_en_a` = 0, `sys_reset` = 1.
  - Then return to IDLE.
- `abort` in PLAY or RAND: go to FIN next cycle. `done` still pulses.
- `start` while not in IDLE is ignored.
- `cycle` saturates at 2^32-1. Its value holds from FIN until the next `start`.
- The LFSR loads the seed (0 replaced by 1) on `start`.
- Memory contents are not reset.

## Timing

- After async reset: state = IDLE, `io_en_a` = 0, `sys_reset` = 1, `busy` = 0, `done` = 0, `cycle` = 0, `ptr` = 0, LFSR = 1. Reset takes effect immediately and is released synchronously by the register clocking.
- `start` sampled at edge N gives entry 0 visible on the outputs after edge N+1, with `busy` high from the same edge.
- Entry k is visible after edge N+1+k.
- `done` pulses one cycle after the last emitted entry: after edge N+1+len+rand_cycles.
- Memory read is combinational on `ptr` into the output register, so latency is one register.
- A write to address A at edge M is readable by a `start` at edge M or later.
- `abort` and end-of-trace in the same cycle: FIN is entered exactly once, with a single `done` pulse.
- Reset during PLAY: outputs return to reset values immediately; the partial run is discarded.

## Structure

- Package `trace_pkg` holds:
  - the state enum (IDLE/PLAY/RAND/FIN);
  - the default values of `EN_W`, `DEPTH` and `RAND_W`;
  - the LFSR tap mask constant;
  - a typedef for the trace entry {rst, en}.
- Sub-module `trace_lfsr`: a Fibonacci LFSR with `load`/`seed`/`step` inputs and a `q` output.
- Memory is a flat register array inside `rule_trace_player`.

## Test plan

- **Reset values:** assert `reset` mid-clock. Outputs go to `io_en_a` = 0 and `sys_reset` = 1 without waiting for an edge; `busy` = 0 and `cycle` = 0.
- **Full trace replay:** load 10 entries {1,0000000}, {0,0000010}, {0,0001101}, {1,0011001}, {1,1100010}, {1,0011010}, {0,1100001}, {0,1001010}, {0,1010101}, {0,1100010}; set `len` = 10, `rand_cycles` = 0; pulse `start`. The outputs show exactly that sequence on cycles 1..10, `done` pulses on cycle 11, and `cycle` = 10.
- **Random extension:** `len` = 2, `rand_cycles` = 5, `seed` = 0xACE1. After 2 trace cycles, 5 cycles follow with `sys_reset` = 0 and `io_en_a` matching the LFSR reference model; `done` pulses at cycle 8.
- **Zero-length run:** `len` = 0, `rand_cycles` = 0, pulse `start`. `done` pulses on the next cycle and `busy` never rises.
- **Abort mid-run:** assert `abort` at entry 3 of 10. Next cycle is FIN with `done` = 1, then IDLE; `cycle` = 4.
- **Write during playback and extra starts:** `wr_en` asserted while `busy` leaves memory unchanged (the next run replays the old data). A `start` pulse during PLAY has no effect.

Source files
------------

// File: rtl/rule_trace_player_pkg.sv
// trace_pkg: shared defaults, FSM state enum, LFSR taps and trace entry layout for rule_trace_player
package trace_pkg;
  localparam int EN_W_DEF = 7;
  localparam int DEPTH_DEF = 16;
  localparam int RAND_W_DEF = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, PLAY, RAND, FIN} state_e;
  typedef struct packed {
    logic rst;
    logic [EN_W_DEF-1:0] en;
  } entry_t;
endpackage

// File: rtl/rule_trace_player_if.sv
// rule_trace_player_if: control/trace-load bus (master = driver, slave = player) plus player status and system outputs
interface rule_trace_player_if
  import trace_pkg::*;
#(
  parameter int EN_W = EN_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH),
  parameter int RAND_W = RAND_W_DEF
);
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [EN_W:0] wr_data;
  logic [AW:0] len;
  logic [15:0] rand_cycles;
  logic [RAND_W-1:0] seed;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic [31:0] cycle;
  logic [EN_W-1:0] io_en_a;
  logic sys_reset;
  modport master (
    output wr_en, wr_addr, wr_data, len, rand_cycles, seed, start, abort,
    input busy, done, cycle, io_en_a, sys_reset
  );
  modport slave (
    input wr_en, wr_addr, wr_data, len, rand_cycles, seed, start, abort,
    output busy, done, cycle, io_en_a, sys_reset
  );
endinterface

// File: rtl/rule_trace_player_lfsr.sv
// trace_lfsr: Fibonacci LFSR, load forces seed (0 becomes 1), step shifts left; q = low OW bits; ports clock, reset, load, step, seed, q
module trace_lfsr
  import trace_pkg::*;
#(
  parameter int W = RAND_W_DEF,
  parameter int OW = EN_W_DEF,
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS)
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic step,
  input  logic [W-1:0] seed,
  output logic [OW-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = load ? (seed == '0 ? W'(1) : seed) : step ? {q_q[W-2:0], ^(q_q & TAPS)} : q_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) q_q <= W'(1);
    else q_q <= q_d;
  assign q = q_q[OW-1:0];
endmodule

// File: rtl/rule_trace_player.sv
// rule_trace_player: replays a loaded {sys_reset, io_en_a} trace then optional LFSR enables; ports clock, reset, rule_trace_player_if.slave bus
module rule_trace_player
  import trace_pkg::*;
#(
  parameter int EN_W = EN_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH),
  parameter int RAND_W = RAND_W_DEF
) (
  input logic clock,
  input logic reset,
  rule_trace_player_if.slave bus
);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  logic [EN_W:0] mem [DEPTH];
  state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0] len_q, len_d;
  logic [15:0] rc_q, rc_d;
  logic [31:0] cycle_q, cycle_d;
  logic [EN_W-1:0] en_q, en_d;
  logic sysrst_q, sysrst_d, busy_q, busy_d, done_q, done_d;
  logic [EN_W-1:0] rnd;
  logic emit, stop;
  trace_lfsr #(.W(RAND_W), .OW(EN_W)) u_lfsr (
    .clock(clock),
    .reset(reset),
    .load(state_q == IDLE && bus.start),
    .step(state_q == RAND),
    .seed(bus.seed),
    .q(rnd)
  );
  assign stop = bus.abort && (state_q == PLAY || state_q == RAND);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    len_d = len_q;
    rc_d = rc_q;
    cycle_d = cycle_q;
    sysrst_d = 1'b1;
    en_d = '0;
    emit = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        ptr_d = '0;
        cycle_d = '0;
        len_d = bus.len > LEN_MAX ? LEN_MAX : bus.len;
        rc_d = bus.rand_cycles;
        state_d = bus.len != '0 ? PLAY : bus.rand_cycles != '0 ? RAND : FIN;
      end
      PLAY: begin
        {sysrst_d, en_d} = mem[ptr_q];
        ptr_d = ptr_q + 1'b1;
        emit = 1'b1;
        state_d = (AW+1)'(ptr_q) != len_q - 1'b1 ? PLAY : rc_q != '0 ? RAND : FIN;
      end
      RAND: begin
        sysrst_d = 1'b0;
        en_d = rnd;
        rc_d = rc_q - 1'b1;
        emit = 1'b1;
        state_d = rc_q == 16'd1 ? FIN : RAND;
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      sysrst_d = 1'b1;
      en_d = '0;
      emit = 1'b0;
    end
    if (emit) cycle_d = cycle_q + 32'(~&cycle_q);
    busy_d = emit;
    done_d = state_q == FIN || stop;
  end
  always_ff @(posedge clock)
    if (bus.wr_en && state_q == IDLE) mem[bus.wr_addr] <= bus.wr_data;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      len_q <= '0;
      rc_q <= '0;
      cycle_q <= '0;
      en_q <= '0;
      sysrst_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      len_q <= len_d;
      rc_q <= rc_d;
      cycle_q <= cycle_d;
      en_q <= en_d;
      sysrst_q <= sysrst_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.cycle = cycle_q;
  assign bus.io_en_a = en_q;
  assign bus.sys_reset = sysrst_q;
endmodule
